gate_test_sequencer: RTL and testbench
======================================

GATE_TEST_SEQUENCER -- requirements
Module: gate_test_sequencer

Interface
REQ-001 Parameter SETTLE, default 2: number of wait cycles between driving a vector and sampling the result; legal range 0..15.
REQ-002 Parameter SEL_LAST, default 15: last gate-select index exercised; legal range 0..15.
REQ-003 clk  input  1  system clock; all logic is on its rising edge.
REQ-004 rst_n  input  1  synchronous active-low reset, sampled on rising clk.
REQ-005 start  input  1  single-cycle request to begin a test run.
REQ-006 result  input  8  gate-bank output for the currently driven select/stimulus.
REQ-007 expected  input  8  golden-model output for the same select/stimulus.
REQ-008 sel  output  4  gate-select index driven to the gate-bank output mux.
REQ-009 stim  output  4  stimulus nibble driven to the gate inputs.
REQ-010 busy  output  1  high while a run is in progress.
REQ-011 done  output  1  high while in DONE, until the next accepted start.
REQ-012 pass  output  1  valid while done is high; 1 means zero mismatches.
REQ-013 err_count  output  8  mismatch count of the current/last run.
REQ-014 fail_sel  output  4  sel of the first mismatching vector; 0 if none.
REQ-015 fail_stim  output  4  stim of the first mismatching vector; 0 if none.

Function
REQ-016 FSM states are IDLE, DRIVE, SETTLE, CHECK and DONE.
REQ-017 In IDLE or DONE, start=1 transitions to DRIVE on the next edge: sel=0, stim=0, err_count=0, fail_sel=0, fail_stim=0, done=0, busy=1.
REQ-018 start is ignored while busy=1.
REQ-019 DRIVE lasts 1 cycle and then enters SETTLE; if SETTLE=0, it goes directly to CHECK.
REQ-020 SETTLE lasts exactly SETTLE cycles, counted by a 4-bit down-counter, and then enters CHECK.
REQ-021 CHECK lasts 1 cycle and compares result with expected over all 8 bits.
REQ-022 On a mismatch in CHECK, err_count increments, saturating at 255.
REQ-023 On the first mismatch of a run, fail_sel and fail_stim capture the current sel and stim; later mismatches leave them unchanged.
REQ-024 After CHECK, stim increments; on the wrap from 15 to 0, sel increments; the FSM then re-enters DRIVE.
REQ-025 After CHECK with sel=SEL_LAST and stim=15, the FSM enters DONE: busy=0, done=1, pass=(err_count==0) including that final check.
REQ-026 Each vector takes SETTLE+2 cycles; DONE is entered (SEL_LAST+1)*16*(SETTLE+2) edges after the start-accept edge (defaults: 1024).
REQ-027 sel and stim are held stable from DRIVE through CHECK of each vector.
REQ-028 In DONE, sel, stim, err_count, fail_sel and fail_stim hold their values.
REQ-029 pass is 0 whenever done=0.

Reset
REQ-030 While rst_n=0 at a rising clk edge, the FSM enters IDLE and every output is driven to 0; this includes a reset mid-run, which abandons the run with no done pulse.
REQ-031 A start coincident with rst_n=0 is discarded.

Configuration
REQ-032 Macro GATESEQ_STOP_ON_FAIL_EN.
REQ-033 With GATESEQ_STOP_ON_FAIL_EN defined, the first mismatch in CHECK moves the FSM directly to DONE: err_count=1, pass=0, fail_sel/fail_stim captured, sel/stim held at the failing vector.
REQ-034 Without GATESEQ_STOP_ON_FAIL_EN, all vectors are always run as in REQ-024/025.

Verification
REQ-035 Defaults, expected tied to result, start pulse -> busy for 1024 cycles, then done=1, pass=1, err_count=0, fail_sel=0, fail_stim=0.
REQ-036 Defaults, expected differs from result only at sel=3/stim=5 and at sel=9/stim=0 -> done with pass=0, err_count=2, fail_sel=3, fail_stim=5.
REQ-037 Build with GATESEQ_STOP_ON_FAIL_EN, same stimulus as REQ-036 -> DONE 4*(16*3+6) = 216 edges after start, err_count=1, sel=3, stim=5.
REQ-038 Drop rst_n=0 for one cycle at cycle 500 of a run -> all outputs 0 and IDLE next cycle; a new start then gives a full clean 1024-cycle run.
REQ-039 SETTLE=0, SEL_LAST=0, expected always inverted from result, start also pulsed mid-run -> mid-run start ignored; done after 32 cycles, err_count=16, fail_sel=0, fail_stim=0.

Source files
------------

// File: rtl/gate_test_sequencer_if.sv
// Gate-bank test port bundle: the controller/gate bank (master) supplies start,
// result and expected; the sequencer (slave) drives select, stimulus and status.
interface gate_test_sequencer_if;
  logic       start;
  logic [7:0] result;
  logic [7:0] expected;
  logic [3:0] sel;
  logic [3:0] stim;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] err_count;
  logic [3:0] fail_sel;
  logic [3:0] fail_stim;

  modport master (
    output start, result, expected,
    input  sel, stim, busy, done, pass, err_count, fail_sel, fail_stim
  );

  modport slave (
    input  start, result, expected,
    output sel, stim, busy, done, pass, err_count, fail_sel, fail_stim
  );
endinterface

// File: rtl/gate_test_sequencer.sv
// Walks every (sel, stim) vector through a gate bank, compares result against
// expected and records mismatches. Optional macro GATESEQ_STOP_ON_FAIL_EN ends a run at the first mismatch.
module gate_test_sequencer #(
  parameter int unsigned SETTLE   = 2,
  parameter int unsigned SEL_LAST = 15
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gate_test_sequencer_if.slave    bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] SETTLE_W   = SETTLE[3:0];
  localparam logic [3:0] SEL_LAST_W = SEL_LAST[3:0];

  state_t     state_r;
  state_t     state_nx_s;
  logic [3:0] cnt_r;
  logic [3:0] cnt_nx_s;
  logic [3:0] sel_r;
  logic [3:0] sel_nx_s;
  logic [3:0] stim_r;
  logic [3:0] stim_nx_s;
  logic [7:0] err_count_r;
  logic [7:0] err_nx_s;
  logic [3:0] fail_sel_r;
  logic [3:0] fail_sel_nx_s;
  logic [3:0] fail_stim_r;
  logic [3:0] fail_stim_nx_s;
  logic       busy_r;
  logic       busy_nx_s;
  logic       done_r;
  logic       done_nx_s;
  logic       pass_r;
  logic       pass_nx_s;

  logic       start_acc_s;
  logic       mismatch_s;
  logic       last_vec_s;
  logic       stop_fail_s;

  assign start_acc_s = bus.start && ((state_r == ST_IDLE) || (state_r == ST_DONE));
  assign mismatch_s  = (bus.result != bus.expected);
  assign last_vec_s  = (sel_r == SEL_LAST_W) && (stim_r == 4'hF);

`ifdef GATESEQ_STOP_ON_FAIL_EN
  assign stop_fail_s = mismatch_s;
`else
  assign stop_fail_s = 1'b0;
`endif

  // State and datapath registers; everything clears while rst_n is low.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      sel_r       <= 4'd0;
      stim_r      <= 4'd0;
      err_count_r <= 8'd0;
      fail_sel_r  <= 4'd0;
      fail_stim_r <= 4'd0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      sel_r       <= sel_nx_s;
      stim_r      <= stim_nx_s;
      err_count_r <= err_nx_s;
      fail_sel_r  <= fail_sel_nx_s;
      fail_stim_r <= fail_stim_nx_s;
      busy_r      <= busy_nx_s;
      done_r      <= done_nx_s;
      pass_r      <= pass_nx_s;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (bus.start) state_nx_s = ST_DRIVE;
        else           state_nx_s = state_r;
      end
      ST_DRIVE: begin
        if (SETTLE_W == 4'd0) state_nx_s = ST_CHECK;
        else                  state_nx_s = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (cnt_r == 4'd0) state_nx_s = ST_CHECK;
        else               state_nx_s = ST_SETTLE;
      end
      ST_CHECK: begin
        if (stop_fail_s || last_vec_s) state_nx_s = ST_DONE;
        else                           state_nx_s = ST_DRIVE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Next values of the datapath and the registered status outputs.
  always_comb begin
    cnt_nx_s       = cnt_r;
    sel_nx_s       = sel_r;
    stim_nx_s      = stim_r;
    err_nx_s       = err_count_r;
    fail_sel_nx_s  = fail_sel_r;
    fail_stim_nx_s = fail_stim_r;

    if (start_acc_s) begin
      sel_nx_s       = 4'd0;
      stim_nx_s      = 4'd0;
      err_nx_s       = 8'd0;
      fail_sel_nx_s  = 4'd0;
      fail_stim_nx_s = 4'd0;
    end else if (state_r == ST_DRIVE) begin
      // Loaded so that SETTLE runs exactly SETTLE cycles ending on zero.
      cnt_nx_s = SETTLE_W - 4'd1;
    end else if (state_r == ST_SETTLE) begin
      cnt_nx_s = cnt_r - 4'd1;
    end else if (state_r == ST_CHECK) begin
      if (mismatch_s) begin
        if (err_count_r == 8'hFF) err_nx_s = 8'hFF;
        else                      err_nx_s = err_count_r + 8'd1;
        // err_count never returns to zero within a run, so zero marks the first mismatch.
        if (err_count_r == 8'd0) begin
          fail_sel_nx_s  = sel_r;
          fail_stim_nx_s = stim_r;
        end else begin
          fail_sel_nx_s  = fail_sel_r;
          fail_stim_nx_s = fail_stim_r;
        end
      end else begin
        err_nx_s = err_count_r;
      end
      if (state_nx_s == ST_DRIVE) begin
        stim_nx_s = stim_r + 4'd1;
        if (stim_r == 4'hF) sel_nx_s = sel_r + 4'd1;
        else                sel_nx_s = sel_r;
      end else begin
        stim_nx_s = stim_r;
      end
    end else begin
      cnt_nx_s = cnt_r;
    end

    case (state_nx_s)
      ST_DRIVE, ST_SETTLE, ST_CHECK: begin
        busy_nx_s = 1'b1;
        done_nx_s = 1'b0;
      end
      ST_DONE: begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b1;
      end
      default: begin
        busy_nx_s = 1'b0;
        done_nx_s = 1'b0;
      end
    endcase
    pass_nx_s = done_nx_s && (err_nx_s == 8'd0);
  end

  assign bus.sel       = sel_r;
  assign bus.stim      = stim_r;
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.err_count = err_count_r;
  assign bus.fail_sel  = fail_sel_r;
  assign bus.fail_stim = fail_stim_r;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Bench for gate_test_sequencer: a vector-index model checked every cycle on two
// instances (defaults, and SETTLE=0/SEL_LAST=0), plus literal end-of-run checks.
module tb_gate_test_sequencer;

`ifdef GATESEQ_STOP_ON_FAIL_EN
  localparam bit STOP = 1'b1;
`else
  localparam bit STOP = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] sel;
    logic [3:0] stim;
    logic       busy;
    logic       done;
    logic       pass;
    logic [7:0] err;
    logic [3:0] fsel;
    logic [3:0] fstim;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  int   pat_a = 0;

  bit   m_run [2];
  int   m_k   [2];
  int   m_pat [2];

  gate_test_sequencer_if ifc_a ();
  gate_test_sequencer_if ifc_b ();

  gate_test_sequencer dut_a (.clk(clk), .rst_n(rst_n), .bus(ifc_a));
  gate_test_sequencer #(.SETTLE(0), .SEL_LAST(0)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifc_b));

  always #5 clk = ~clk;

  // Pattern 1: mismatches at (3,5) and (9,0); pattern 2: every vector mismatches.
  function automatic bit bad(input int p, input int s, input int t);
    if (p == 1) return (s == 3 && t == 5) || (s == 9 && t == 0);
    if (p == 2) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [7:0] flip(input int p, input logic [3:0] s, input logic [3:0] t);
    if (p == 2) return 8'hFF;
    if (p == 1 && s == 4'd3 && t == 4'd5) return 8'h01;
    if (p == 1 && s == 4'd9 && t == 4'd0) return 8'h80;
    return 8'h00;
  endfunction

  // Gate bank: result is a fixed function of the vector, expected flips bits on bad vectors.
  assign ifc_a.result   = {ifc_a.sel, ifc_a.stim} ^ 8'hA5;
  assign ifc_a.expected = ifc_a.result ^ flip(pat_a, ifc_a.sel, ifc_a.stim);
  assign ifc_b.result   = {ifc_b.sel, ifc_b.stim} ^ 8'h3C;
  assign ifc_b.expected = ~ifc_b.result;

  function automatic int end_edges(input int s, input int sl, input int p);
    int per = s + 2;
    int nvec = (sl + 1) * 16;
    if (STOP) begin
      for (int v = 0; v < nvec; v++) if (bad(p, v / 16, v % 16)) return (v + 1) * per;
    end
    return nvec * per;
  endfunction

  // Outputs as a function of edges elapsed since the start was accepted.
  function automatic exp_t model(input bit run, input int k_in, input int s, input int sl, input int p);
    exp_t e;
    int per, k, chk, cnt, first, v, endk;
    e = '0;
    if (!run) return e;
    per = s + 2;
    endk = end_edges(s, sl, p);
    k = (k_in > endk) ? endk : k_in;
    chk = k / per;
    cnt = 0;
    first = -1;
    for (int i = 0; i < chk; i++) begin
      if (bad(p, i / 16, i % 16)) begin
        if (first < 0) first = i;
        cnt++;
      end
    end
    e.err = (cnt > 255) ? 8'd255 : 8'(cnt);
    if (first >= 0) begin
      e.fsel  = 4'(first / 16);
      e.fstim = 4'(first % 16);
    end
    v = (k >= endk) ? chk - 1 : chk;
    e.sel  = 4'(v / 16);
    e.stim = 4'(v % 16);
    e.busy = (k < endk);
    e.done = (k >= endk);
    e.pass = e.done && (cnt == 0);
    return e;
  endfunction

  // Model run trackers: start is accepted only when the model is not busy.
  always @(posedge clk) begin
    if (!rst_n) m_run[0] <= 1'b0;
    else if (ifc_a.start && !(m_run[0] && m_k[0] < end_edges(2, 15, m_pat[0]))) begin
      m_run[0] <= 1'b1; m_k[0] <= 0; m_pat[0] <= pat_a;
    end else if (m_run[0]) m_k[0] <= m_k[0] + 1;
  end

  always @(posedge clk) begin
    if (!rst_n) m_run[1] <= 1'b0;
    else if (ifc_b.start && !(m_run[1] && m_k[1] < end_edges(0, 0, 2))) begin
      m_run[1] <= 1'b1; m_k[1] <= 0; m_pat[1] <= 2;
    end else if (m_run[1]) m_k[1] <= m_k[1] + 1;
  end

  function automatic exp_t act_a();
    return '{ifc_a.sel, ifc_a.stim, ifc_a.busy, ifc_a.done, ifc_a.pass,
             ifc_a.err_count, ifc_a.fail_sel, ifc_a.fail_stim};
  endfunction

  function automatic exp_t act_b();
    return '{ifc_b.sel, ifc_b.stim, ifc_b.busy, ifc_b.done, ifc_b.pass,
             ifc_b.err_count, ifc_b.fail_sel, ifc_b.fail_stim};
  endfunction

  task automatic cmp_vec(input string name, input exp_t got, input exp_t want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s t=%0t: got sel=%0d stim=%0d busy=%b done=%b pass=%b err=%0d fsel=%0d fstim=%0d; want sel=%0d stim=%0d busy=%b done=%b pass=%b err=%0d fsel=%0d fstim=%0d",
               name, $time, got.sel, got.stim, got.busy, got.done, got.pass, got.err, got.fsel, got.fstim,
               want.sel, want.stim, want.busy, want.done, want.pass, want.err, want.fsel, want.fstim);
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, got, want);
    end
  endtask

  // Every-cycle comparison against the model, away from the rising edge.
  always @(negedge clk) begin
    cmp_vec("cycle_a", act_a(), model(m_run[0], m_k[0], 2, 15, m_pat[0]));
    cmp_vec("cycle_b", act_b(), model(m_run[1], m_k[1], 0, 0, 2));
  end

  task automatic pulse_a(input int p);
    pat_a = p;
    ifc_a.start = 1'b1;
    @(negedge clk);
    ifc_a.start = 1'b0;
  endtask

  // Counts edges after the accept edge until done, bounded; optional mid-run start on B.
  task automatic wait_done(input int which, input int poke_at, output int n);
    n = 0;
    while (n < 5000 && !((which == 0) ? ifc_a.done : ifc_b.done)) begin
      if (which == 1) ifc_b.start = (n == poke_at);
      @(negedge clk);
      n++;
    end
    ifc_b.start = 1'b0;
  endtask

  initial begin
    int n;
    ifc_a.start = 1'b0;
    ifc_b.start = 1'b0;
    rst_n = 1'b0;
    ifc_a.start = 1'b1;
    repeat (3) @(negedge clk);
    ifc_a.start = 1'b0;
    chk("reset_a_zero", int'(act_a()), 0);
    chk("reset_b_zero", int'(act_b()), 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("start_in_reset_dropped", ifc_a.busy, 0);

    // Clean run.
    pulse_a(0);
    chk("clean_busy_first", ifc_a.busy, 1);
    wait_done(0, -1, n);
    chk("clean_len", n, 1024);
    chk("clean_pass", ifc_a.pass, 1);
    chk("clean_err", ifc_a.err_count, 0);
    chk("clean_fsel", ifc_a.fail_sel, 0);
    chk("clean_fstim", ifc_a.fail_stim, 0);

    // Two mismatches, one on bit 0 and one on bit 7.
    pulse_a(1);
    chk("two_pass_cleared", ifc_a.pass, 0);
    wait_done(0, -1, n);
    chk("two_len", n, STOP ? 216 : 1024);
    chk("two_pass", ifc_a.pass, 0);
    chk("two_err", ifc_a.err_count, STOP ? 1 : 2);
    chk("two_fsel", ifc_a.fail_sel, 3);
    chk("two_fstim", ifc_a.fail_stim, 5);
    chk("two_sel_hold", ifc_a.sel, STOP ? 3 : 15);
    chk("two_stim_hold", ifc_a.stim, STOP ? 5 : 15);

    // Reset at cycle 500 abandons the run, then a fresh clean run.
    pulse_a(0);
    repeat (499) @(negedge clk);
    chk("midrst_busy_before", ifc_a.busy, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("midrst_all_zero", int'(act_a()), 0);
    @(negedge clk);
    chk("midrst_no_done", ifc_a.done, 0);
    pulse_a(0);
    wait_done(0, -1, n);
    chk("after_rst_len", n, 1024);
    chk("after_rst_pass", ifc_a.pass, 1);

    // Every vector mismatches: error count saturates.
    pulse_a(2);
    wait_done(0, -1, n);
    chk("sat_err", ifc_a.err_count, STOP ? 1 : 255);
    chk("sat_fsel", ifc_a.fail_sel, 0);
    chk("sat_fstim", ifc_a.fail_stim, 0);

    // Minimal instance, all mismatching, start re-pulsed mid-run.
    ifc_b.start = 1'b1;
    @(negedge clk);
    ifc_b.start = 1'b0;
    wait_done(1, 10, n);
    chk("b_len", n, STOP ? 2 : 32);
    chk("b_err", ifc_b.err_count, STOP ? 1 : 16);
    chk("b_pass", ifc_b.pass, 0);
    chk("b_fsel", ifc_b.fail_sel, 0);
    chk("b_fstim", ifc_b.fail_stim, 0);
    repeat (3) @(negedge clk);
    chk("b_done_hold", ifc_b.done, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_cmp, n_fail);
    $finish;
  end

endmodule
